// File: rtl/key_pkg.sv
// key_pkg: shared types and helpers for the push-button debounce path.
//   key_state_t      : debounce FSM states
//   debounce_cnt_max : terminal count of the bounce-filter counter
package key_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILT_DOWN = 2'd1,
    DOWN      = 2'd2,
    FILT_UP   = 2'd3
  } key_state_t;

  // Number of clock cycles in the filter window, minus one.
  function automatic int debounce_cnt_max(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms - 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchroniser for asynchronous inputs.
//   clk   : destination clock
//   reset : asynchronous, active-low reset (both flops load RST_VAL)
//   i_d   : asynchronous input
//   o_q   : synchronised output
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_filter.sv
// key_filter: debounce and edge qualification for one active-low push button.
//   clk              : system clock, rising edge
//   reset            : asynchronous, active-low reset
//   key_in           : raw button, 0 = pressed, asynchronous to clk
//   key_flag         : one-cycle pulse on a confirmed press
//   key_release_flag : one-cycle pulse on a confirmed release
//   key_state        : debounced level, 0 = pressed, 1 = released
module key_filter
  import key_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_flag,
  output logic key_release_flag,
  output logic key_state
);

  localparam int CNT_MAX = debounce_cnt_max(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (CNT_MAX < 1) begin : g_bad_window
      $error("key_filter: debounce window must be at least two clock cycles");
    end
  endgenerate

  logic             w_key_s;
  logic             r_key_d;
  logic             w_fall;
  logic             w_rise;
  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_key_flag;
  logic             r_rel_flag;
  logic             r_level;
  logic             w_flag_nxt;
  logic             w_rel_nxt;
  logic             w_level_nxt;

  // Idle level of the button is high, so the synchroniser resets to 1 and a
  // key already held low at reset release shows up as a fresh falling edge.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (key_in),
    .o_q   (w_key_s)
  );

  assign w_fall = r_key_d & ~w_key_s;
  assign w_rise = ~r_key_d & w_key_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_d    <= 1'b1;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_key_flag <= 1'b0;
      r_rel_flag <= 1'b0;
      r_level    <= 1'b1;
    end else begin
      r_key_d    <= w_key_s;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_key_flag <= w_flag_nxt;
      r_rel_flag <= w_rel_nxt;
      r_level    <= w_level_nxt;
    end
  end

  // The counter saturates at CNT_LAST: reaching it with the level still
  // qualifying completes the window and leaves the filter state, so it
  // never wraps. Any return to the stable level abandons the window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flag_nxt  = 1'b0;
    w_rel_nxt   = 1'b0;
    w_level_nxt = r_level;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) begin
          w_state_nxt = FILT_DOWN;
        end
      end
      FILT_DOWN: begin
        if (w_key_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
          w_flag_nxt  = 1'b1;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      DOWN: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = FILT_UP;
        end
      end
      FILT_UP: begin
        if (!w_key_s) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_rel_nxt   = 1'b1;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign key_flag         = r_key_flag;
  assign key_release_flag = r_rel_flag;
  assign key_state        = r_level;

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: randomized and directed stimulus for key_filter, checked
// against a run-length reference model of the debounce rules.
module tb_key_filter;

  localparam int CLK_HZ  = 1000;
  localparam int DMS     = 10;
  localparam int CNT_MAX = 9;
  // Consecutive sampled edges at the new level needed before a pulse:
  // one edge-detect edge plus CNT_MAX+1 filter edges.
  localparam int QUAL    = CNT_MAX + 2;
  // key_in change after edge E -> pulse observed at edge E+LAT.
  localparam int LAT     = CNT_MAX + 4;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic key_in = 1'b1;
  logic key_flag;
  logic key_release_flag;
  logic key_state;

  key_filter #(
    .CLK_FREQ_HZ (CLK_HZ),
    .DEBOUNCE_MS (DMS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .key_in           (key_in),
    .key_flag         (key_flag),
    .key_release_flag (key_release_flag),
    .key_state        (key_state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_flag = 0;
  int n_rel  = 0;
  int last_flag = -1000;
  int last_rel  = -1000;

  // Reference model: two-sample delay line, debounced level, run length.
  logic m_p0, m_p1, m_lvl, m_flag, m_rel;
  int   m_run;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_p0   = 1'b1;
    m_p1   = 1'b1;
    m_lvl  = 1'b1;
    m_run  = 0;
    m_flag = 1'b0;
    m_rel  = 1'b0;
  endtask

  task automatic model_edge(input logic kin);
    logic ks;
    ks     = m_p1;
    m_p1   = m_p0;
    m_p0   = kin;
    m_flag = 1'b0;
    m_rel  = 1'b0;
    if (ks !== m_lvl) begin
      m_run++;
      if (m_run == QUAL) begin
        m_lvl = ks;
        m_run = 0;
        if (ks == 1'b0) m_flag = 1'b1;
        else            m_rel  = 1'b1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step();
    logic kin;
    logic rs;
    kin = key_in;
    rs  = reset;
    @(posedge clk);
    cyc++;
    if (rs) model_edge(kin);
    else    model_reset();
    #1;
    chk("key_flag", key_flag, m_flag);
    chk("key_release_flag", key_release_flag, m_rel);
    chk("key_state", key_state, m_lvl);
    if (key_flag) begin
      n_flag++;
      last_flag = cyc;
    end
    if (key_release_flag) begin
      n_rel++;
      last_rel = cyc;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int e0;
  int f0;
  int r0;

  initial begin
    model_reset();

    // Reset held with the key already pressed.
    reset  = 1'b0;
    key_in = 1'b0;
    steps(5);
    chk("rst_state", key_state, 1);
    chk("rst_flags", {key_flag, key_release_flag}, 0);
    reset = 1'b1;
    e0 = cyc;
    f0 = n_flag;
    steps(20);
    chk("rst_press_cnt", n_flag - f0, 1);
    chk("rst_press_lat", last_flag - e0, LAT);
    key_in = 1'b1;
    steps(30);

    // Clean press held for a long time: one pulse, no auto-repeat.
    e0 = cyc;
    f0 = n_flag;
    key_in = 1'b0;
    steps(1000);
    chk("press_cnt", n_flag - f0, 1);
    chk("press_lat", last_flag - e0, LAT);
    chk("press_state", key_state, 0);

    // Clean release.
    e0 = cyc;
    f0 = n_flag;
    r0 = n_rel;
    key_in = 1'b1;
    steps(30);
    chk("release_cnt", n_rel - r0, 1);
    chk("release_lat", last_rel - e0, LAT);
    chk("release_noflag", n_flag - f0, 0);
    chk("release_state", key_state, 1);

    // Bouncy press: 0/1/0/1/0 at 3-cycle intervals, then held low.
    e0 = cyc;
    f0 = n_flag;
    key_in = 1'b0; steps(3);
    key_in = 1'b1; steps(3);
    key_in = 1'b0; steps(3);
    key_in = 1'b1; steps(3);
    key_in = 1'b0; steps(40);
    chk("bounce_cnt", n_flag - f0, 1);
    chk("bounce_lat", last_flag - e0, 12 + LAT);
    key_in = 1'b1;
    steps(30);

    // Glitch of CNT_MAX cycles is rejected.
    f0 = n_flag;
    r0 = n_rel;
    key_in = 1'b0; steps(CNT_MAX);
    key_in = 1'b1; steps(30);
    chk("glitch_flag", n_flag - f0, 0);
    chk("glitch_rel", n_rel - r0, 0);
    chk("glitch_state", key_state, 1);

    // Reset asserted part-way through press qualification.
    f0 = n_flag;
    key_in = 1'b0;
    steps(8);
    chk("midrst_nopulse", n_flag - f0, 0);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_state", key_state, 1);
    chk("midrst_flags", {key_flag, key_release_flag}, 0);
    steps(3);
    reset = 1'b1;
    e0 = cyc;
    steps(25);
    chk("midrst_cnt", n_flag - f0, 1);
    chk("midrst_lat", last_flag - e0, LAT);
    key_in = 1'b1;
    steps(30);

    // Random bounce and hold patterns.
    for (int i = 0; i < 200; i++) begin
      key_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) steps(int'($urandom_range(12, 30)));
      else                           steps(int'($urandom_range(1, 12)));
    end
    key_in = 1'b1;
    steps(30);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
